input_router: RTL and testbench

- Sits directly downstream of the handshake-to-pulse converter, which emits one single-cycle pulse per accepted input byte, tagged key/data.
- Key bytes are assembled into a KEY_BYTES-wide shadow register and published atomically with a one-cycle load pulse to the cipher core.
- Data bytes are buffered in a small FIFO and presented to the cipher core over a valid/ready handshake.
- Drops and key-sequence errors are reported as sticky status flags.

---
 rtl/input_router.sv | 195 +++++++++++++++++++
 tb/tb_input_router.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_router.sv
// Routes tagged byte pulses: key bytes into an atomically loaded key register, data bytes into a FIFO.
// Optional INPUT_ROUTER_KEY_CHECKSUM_EN adds key_checksum and key_count outputs.
module input_router #(
    parameter int unsigned KEY_BYTES  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      in_byte,
    input  logic                            in_is_key,
    input  logic                            in_pulse,
    output logic [7:0]                      data_out,
    output logic                            data_valid,
    input  logic                            data_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [8*KEY_BYTES-1:0]          key_out,
    output logic                            key_load,
    output logic                            key_busy,
    output logic                            overflow,
    output logic                            key_error,
    input  logic                            clear_errors
`ifdef INPUT_ROUTER_KEY_CHECKSUM_EN
    ,
    output logic [7:0]                      key_checksum,
    output logic [7:0]                      key_count
`endif
);

    localparam int unsigned KW = 8 * KEY_BYTES;
    localparam int unsigned SW = KW - 8;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned NW = (KEY_BYTES > 2) ? $clog2(KEY_BYTES) : 1;
    localparam logic [NW-1:0] CNT_LAST = NW'(KEY_BYTES - 1);

    typedef enum logic {
        K_IDLE,
        K_COLLECT
    } kstate_e;

    logic key_pulse;
    logic data_pulse;

    assign key_pulse  = in_pulse & in_is_key;
    assign data_pulse = in_pulse & ~in_is_key;

    // ------------------------------------------------------------------
    // Key assembly FSM
    // ------------------------------------------------------------------
    kstate_e         state_q;
    logic [NW-1:0]   cnt_q;
    logic [SW-1:0]   shadow_q;
    logic [KW-1:0]   key_out_q;
    logic            key_load_q;
    logic            key_err_q;
`ifdef INPUT_ROUTER_KEY_CHECKSUM_EN
    logic [7:0]      xor_q;
    logic [7:0]      csum_q;
    logic [7:0]      kcnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= K_IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            key_out_q  <= '0;
            key_load_q <= 1'b0;
            key_err_q  <= 1'b0;
`ifdef INPUT_ROUTER_KEY_CHECKSUM_EN
            xor_q      <= '0;
            csum_q     <= '0;
            kcnt_q     <= '0;
`endif
        end else begin
            key_load_q <= 1'b0;
            // Clear first so a same-cycle abort below takes priority.
            if (clear_errors) begin
                key_err_q <= 1'b0;
            end
            case (state_q)
                K_IDLE: begin
                    if (key_pulse) begin
                        shadow_q <= SW'(in_byte);
                        cnt_q    <= NW'(1);
                        state_q  <= K_COLLECT;
`ifdef INPUT_ROUTER_KEY_CHECKSUM_EN
                        xor_q    <= in_byte;
`endif
                    end
                end
                K_COLLECT: begin
                    if (key_pulse) begin
                        if (cnt_q == CNT_LAST) begin
                            key_out_q  <= {shadow_q, in_byte};
                            key_load_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= K_IDLE;
`ifdef INPUT_ROUTER_KEY_CHECKSUM_EN
                            csum_q     <= xor_q ^ in_byte;
                            if (kcnt_q != 8'hFF) begin
                                kcnt_q <= kcnt_q + 8'd1;
                            end
`endif
                        end else begin
                            shadow_q <= SW'({shadow_q, in_byte});
                            cnt_q    <= cnt_q + NW'(1);
`ifdef INPUT_ROUTER_KEY_CHECKSUM_EN
                            xor_q    <= xor_q ^ in_byte;
`endif
                        end
                    end else if (data_pulse) begin
                        key_err_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= K_IDLE;
                    end
                end
                default: begin
                    state_q <= K_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign key_out   = key_out_q;
    assign key_load  = key_load_q;
    assign key_busy  = (state_q == K_COLLECT);
    assign key_error = key_err_q;
`ifdef INPUT_ROUTER_KEY_CHECKSUM_EN
    assign key_checksum = csum_q;
    assign key_count    = kcnt_q;
`endif

    // ------------------------------------------------------------------
    // Data FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          ovf_set;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = data_valid & data_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = data_pulse & (~full | pop);
    assign ovf_set = data_pulse & full & ~pop;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= in_byte;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (clear_errors) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign data_valid = (count_q != '0);
    assign data_out   = data_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_input_router.sv
// Scoreboard bench for input_router: queue-based reference model plus an independent pop monitor.
module tb_input_router;

    localparam int KB    = 4;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         in_byte;
    logic               in_is_key;
    logic               in_pulse;
    logic [7:0]         data_out;
    logic               data_valid;
    logic               data_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [8*KB-1:0]    key_out;
    logic               key_load;
    logic               key_busy;
    logic               overflow;
    logic               key_error;
    logic               clear_errors;
`ifdef INPUT_ROUTER_KEY_CHECKSUM_EN
    logic [7:0]         key_checksum;
    logic [7:0]         key_count;
`endif

    always #5 clk = ~clk;

    input_router #(.KEY_BYTES(KB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_byte      (in_byte),
        .in_is_key    (in_is_key),
        .in_pulse     (in_pulse),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .fifo_count   (fifo_count),
        .key_out      (key_out),
        .key_load     (key_load),
        .key_busy     (key_busy),
        .overflow     (overflow),
        .key_error    (key_error),
        .clear_errors (clear_errors)
`ifdef INPUT_ROUTER_KEY_CHECKSUM_EN
        ,
        .key_checksum (key_checksum),
        .key_count    (key_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: byte queues for FIFO contents, scoreboard and the partial key.
    logic [7:0]      mq[$];
    logic [7:0]      sb[$];
    logic [7:0]      kq[$];
    logic [8*KB-1:0] m_key;
    bit              m_load;
    bit              m_ovf;
    bit              m_kerr;
    logic [7:0]      m_csum;
    int              m_kcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        kq.delete();
        m_key  = '0;
        m_load = 1'b0;
        m_ovf  = 1'b0;
        m_kerr = 1'b0;
        m_csum = '0;
        m_kcnt = 0;
    endtask

    task automatic model_apply(input bit p, input bit k, input logic [7:0] b, input bit r, input bit c);
        bit pop;
        bit acc;
        bit ovf_set;
        bit kerr_set;
        logic [7:0] cs;
        pop      = (mq.size() != 0) && r;
        acc      = 1'b0;
        ovf_set  = 1'b0;
        kerr_set = 1'b0;
        m_load   = 1'b0;
        if (p && !k) begin
            if (kq.size() != 0) begin
                kq.delete();
                kerr_set = 1'b1;
            end
            if (mq.size() < DEPTH || pop) acc = 1'b1;
            else ovf_set = 1'b1;
        end else if (p && k) begin
            kq.push_back(b);
            if (kq.size() == KB) begin
                m_key = '0;
                cs    = '0;
                foreach (kq[i]) begin
                    m_key = {m_key[8*KB-9:0], kq[i]};
                    cs    = cs ^ kq[i];
                end
                m_load = 1'b1;
                m_csum = cs;
                if (m_kcnt < 255) m_kcnt++;
                kq.delete();
            end
        end
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(b);
            sb.push_back(b);
        end
        m_ovf  = ovf_set  ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_kerr = kerr_set ? 1'b1 : (c ? 1'b0 : m_kerr);
    endtask

    task automatic check_state();
        chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
        chk("data_valid", 64'(data_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) chk("data_head", 64'(data_out), 64'(mq[0]));
        chk("key_out",   64'(key_out),   64'(m_key));
        chk("key_load",  64'(key_load),  64'(m_load));
        chk("key_busy",  64'(key_busy),  64'(kq.size() != 0));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        chk("key_error", 64'(key_error), 64'(m_kerr));
`ifdef INPUT_ROUTER_KEY_CHECKSUM_EN
        chk("key_checksum", 64'(key_checksum), 64'(m_csum));
        chk("key_count",    64'(key_count),    64'(m_kcnt));
`endif
    endtask

    // One clock: check the state produced by the previous inputs, then drive new ones.
    task automatic step(input bit p, input bit k, input logic [7:0] b, input bit r, input bit c);
        @(posedge clk);
        #1;
        check_state();
        in_pulse     = p;
        in_is_key    = k;
        in_byte      = b;
        data_ready   = r;
        clear_errors = c;
        model_apply(p, k, b, r, c);
    endtask

    task automatic sync_reset();
        @(posedge clk);
        #1;
        in_pulse = 1'b0; in_is_key = 1'b0; in_byte = '0; data_ready = 1'b0; clear_errors = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every accepted head must match the oldest scoreboard entry.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (!rst && data_valid && data_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h expected no transfer (t=%0t)", data_out, $time);
            end else begin
                exp_b = sb.pop_front();
                chk("pop_order", 64'(data_out), 64'(exp_b));
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_pulse = 1'b0; in_is_key = 1'b0; in_byte = '0; data_ready = 1'b0; clear_errors = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state();
        chk("reset_data_out", 64'(data_out), 64'h0);
        rst = 1'b0;

        // Key load
        step(1, 1, 8'h11, 0, 0);
        step(1, 1, 8'h22, 0, 0);
        step(1, 1, 8'h33, 0, 0);
        step(1, 1, 8'h44, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("tp_key_out",  64'(key_out),  64'h11223344);
        chk("tp_key_load", 64'(key_load), 64'h1);
        step(0, 0, 8'h00, 0, 0);

        // FIFO order
        step(1, 0, 8'hA0, 0, 0);
        step(1, 0, 8'hA1, 0, 0);
        step(1, 0, 8'hA2, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("tp_count3", 64'(fifo_count), 64'd3);
        chk("tp_headA0", 64'(data_out),   64'hA0);
        repeat (4) step(0, 0, 8'h00, 1, 0);

        // Overflow and clear
        for (int i = 1; i <= 5; i++) step(1, 0, 8'(i), 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("tp_ovf_count", 64'(fifo_count), 64'd4);
        chk("tp_ovf_flag",  64'(overflow),   64'h1);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);
        chk("tp_ovf_clear", 64'(overflow), 64'h0);
        repeat (5) step(0, 0, 8'h00, 1, 0);

        // Full with concurrent push/pop
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h61 + i), 0, 0);
        step(1, 0, 8'h77, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("tp_full_count", 64'(fifo_count), 64'd4);
        chk("tp_full_ovf",   64'(overflow),   64'h0);
        repeat (5) step(0, 0, 8'h00, 1, 0);

        // Key abort from a fresh reset
        sync_reset();
        step(1, 1, 8'hAA, 0, 0);
        step(1, 1, 8'hBB, 0, 0);
        step(1, 0, 8'h5C, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("tp_abort_err", 64'(key_error),  64'h1);
        chk("tp_abort_key", 64'(key_out),    64'h0);
        chk("tp_abort_fifo", 64'(data_out),  64'h5C);
        for (int i = 1; i <= 4; i++) step(1, 1, 8'(i), 1, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("tp_abort_reload", 64'(key_out), 64'h01020304);

        // Async reset mid-collection and mid-FIFO
        step(1, 1, 8'hC1, 0, 0);
        step(1, 1, 8'hC2, 0, 0);
        step(1, 0, 8'hD1, 0, 0);
        step(1, 0, 8'hD2, 0, 0);
        @(posedge clk);
        #1;
        check_state();
        in_pulse = 1'b0; in_is_key = 1'b0; in_byte = '0; data_ready = 1'b0; clear_errors = 1'b0;
        model_apply(0, 0, 8'h00, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("ar_key_out",    64'(key_out),    64'h0);
        chk("ar_key_busy",   64'(key_busy),   64'h0);
        chk("ar_data_valid", 64'(data_valid), 64'h0);
        chk("ar_fifo_count", 64'(fifo_count), 64'h0);
        chk("ar_key_error",  64'(key_error),  64'h0);
        chk("ar_data_out",   64'(data_out),   64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 1, 8'hE1, 0, 0);
        step(1, 1, 8'hE2, 0, 0);
        step(1, 1, 8'hE3, 0, 0);
        step(1, 1, 8'hE4, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("ar_reload", 64'(key_out), 64'hE1E2E3E4);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
        end
        repeat (8) step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
